// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: owns HI/LO, runs a multi-cycle multiply or a
// radix-2 restoring divide, and stalls the pipeline until the result is written.
module mdu_ctrl #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic [3:0]  mduop_i,
    input  logic [31:0] opr1_i,
    input  logic [31:0] opr2_i,
    output logic        stallreq_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] mf_o
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
    localparam logic [5:0] CNT_MUL  = 6'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      state, state_nx;
    logic [5:0]  cnt, cnt_nx;
    logic [31:0] opa, opa_nx, opb, opb_nx, rem, rem_nx;
    logic        mul_sgn, mul_sgn_nx, neg_q, neg_q_nx, neg_r, neg_r_nx;
    logic        hi_we, lo_we;
    logic [31:0] hi_d, lo_d;

    // Multiply datapath: sign/zero-extend to 64 bits, low 64 bits of the product.
    logic [63:0] mul_a, mul_b, prod;
    assign mul_a = mul_sgn ? {{32{opa[31]}}, opa} : {32'b0, opa};
    assign mul_b = mul_sgn ? {{32{opb[31]}}, opb} : {32'b0, opb};
    assign prod  = mul_a * mul_b;

    // One restoring-divide step; opa shifts the dividend out and the quotient in.
    logic [32:0] rem_sh, diff;
    logic        q_bit;
    logic [31:0] rem_step, quo_step, q_fix, r_fix;
    assign rem_sh   = {rem, opa[31]};
    assign diff     = rem_sh - {1'b0, opb};
    assign q_bit    = ~diff[32];
    assign rem_step = q_bit ? diff[31:0] : rem_sh[31:0];
    assign quo_step = {opa[30:0], q_bit};
    assign q_fix    = neg_q ? -quo_step : quo_step;
    assign r_fix    = neg_r ? -rem_step : rem_step;

    logic        div_sgn;
    assign div_sgn = (mduop_i == OP_DIV);

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        opa_nx     = opa;
        opb_nx     = opb;
        rem_nx     = rem;
        mul_sgn_nx = mul_sgn;
        neg_q_nx   = neg_q;
        neg_r_nx   = neg_r;
        stallreq_o = 1'b0;
        hi_we      = 1'b0;
        lo_we      = 1'b0;
        hi_d       = 32'b0;
        lo_d       = 32'b0;
        if (flush_i) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    case (mduop_i)
                        OP_MULT, OP_MULTU: begin
                            stallreq_o = 1'b1;
                            opa_nx     = opr1_i;
                            opb_nx     = opr2_i;
                            mul_sgn_nx = (mduop_i == OP_MULT);
                            cnt_nx     = CNT_MUL;
                            state_nx   = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (opr2_i != 32'b0) begin
                                stallreq_o = 1'b1;
                                opa_nx     = (div_sgn && opr1_i[31]) ? -opr1_i : opr1_i;
                                opb_nx     = (div_sgn && opr2_i[31]) ? -opr2_i : opr2_i;
                                neg_q_nx   = div_sgn && (opr1_i[31] ^ opr2_i[31]);
                                neg_r_nx   = div_sgn && opr1_i[31];
                                rem_nx     = 32'b0;
                                cnt_nx     = 6'd0;
                                state_nx   = S_DIV;
                            end
                        end
                        OP_MTHI: begin
                            hi_we = 1'b1;
                            hi_d  = opr1_i;
                        end
                        OP_MTLO: begin
                            lo_we = 1'b1;
                            lo_d  = opr1_i;
                        end
                        default: ;
                    endcase
                end
                S_MUL: begin
                    stallreq_o = 1'b1;
                    cnt_nx     = cnt - 6'd1;
                    if (cnt == 6'd0) begin
                        hi_we    = 1'b1;
                        lo_we    = 1'b1;
                        hi_d     = prod[63:32];
                        lo_d     = prod[31:0];
                        cnt_nx   = 6'd0;
                        state_nx = S_DONE;
                    end
                end
                S_DIV: begin
                    stallreq_o = 1'b1;
                    opa_nx     = quo_step;
                    rem_nx     = rem_step;
                    cnt_nx     = cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        hi_we    = 1'b1;
                        lo_we    = 1'b1;
                        hi_d     = r_fix;
                        lo_d     = q_fix;
                        cnt_nx   = 6'd0;
                        state_nx = S_DONE;
                    end
                end
                // The finished instruction is still in execute; wait for it to move on.
                S_DONE: begin
                    if (!stall_i) state_nx = S_IDLE;
                end
                default: state_nx = S_IDLE;
            endcase
        end
        if (rst) stallreq_o = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 6'd0;
            opa     <= 32'b0;
            opb     <= 32'b0;
            rem     <= 32'b0;
            mul_sgn <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            hi_o    <= 32'b0;
            lo_o    <= 32'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            opa     <= opa_nx;
            opb     <= opb_nx;
            rem     <= rem_nx;
            mul_sgn <= mul_sgn_nx;
            neg_q   <= neg_q_nx;
            neg_r   <= neg_r_nx;
            if (hi_we) hi_o <= hi_d;
            if (lo_we) lo_o <= lo_d;
        end
    end

    assign mf_o = (mduop_i == OP_MFHI) ? hi_o :
                  (mduop_i == OP_MFLO) ? lo_o : 32'b0;

endmodule
